// File: rtl/seven_seg_display_ctrl_if.sv
// Source-side bus of the seven-segment scan controller: both display sources,
// the source 1 req/gnt handshake and the per-digit blink / decimal-point masks.
interface seven_seg_display_ctrl_if;
  logic [15:0] src0_data;
  logic [15:0] src1_data;
  logic        src1_req;
  logic        src1_gnt;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;

  // clock/alarm datapath side
  modport master (
    output src0_data, src1_data, src1_req, blink_mask, dp_mask,
    input  src1_gnt
  );

  // display controller side
  modport slave (
    input  src0_data, src1_data, src1_req, blink_mask, dp_mask,
    output src1_gnt
  );
endinterface

// File: rtl/seven_seg_display_ctrl.sv
// 4-digit multiplexed seven-segment scan controller and two-source arbiter.
// Each digit is driven for DWELL cycles, separated by BLANK all-off cycles.
// Ownership (source 0 default, source 1 by req/gnt) only changes at frame end,
// so a frame never mixes sources. Per-digit blink with a frame-based period.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seven_seg_display_ctrl #(
  parameter int DWELL        = 250,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          base_scan_clock,
  input  logic                          RESETn,
  seven_seg_display_ctrl_if.slave       bus,
  output logic [3:0]                    scan_out,
  output logic [6:0]                    seg_out,
  output logic                          dp_out
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK - 1);
  localparam logic [7:0]    FRAMES_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          owner_q, owner_d;
  logic [7:0]    frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [3:0]    scan_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  logic [15:0]   own_data;
  logic [3:0]    nib;
  logic          lz_blank;
  logic          blink_off;

  // hex digit to active-low segments, a..g at bits 0..6
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      default: hex2seg = 7'b0001110;
    endcase
  endfunction

  // during BLANK, dig_q already points at the digit about to be driven
  assign own_data  = owner_q ? bus.src1_data : bus.src0_data;
  assign nib       = own_data[{dig_q, 2'b00} +: 4];
  assign blink_off = phase_q & bus.blink_mask[dig_q];
  assign bus.src1_gnt = owner_q;

`ifdef LEADING_ZERO_BLANK_EN
  // a digit is a leading zero when it and every higher digit are zero
  always_comb begin
    case (dig_q)
      2'd3:    lz_blank = (own_data[15:12] == 4'h0);
      2'd2:    lz_blank = (own_data[15:8]  == 8'h0);
      2'd1:    lz_blank = (own_data[15:4]  == 12'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // scan sequencing, arbitration and blink timing; next values of registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    owner_d = owner_q;
    frame_d = frame_q;
    phase_d = phase_q;
    scan_d  = scan_out;
    seg_d   = seg_out;
    dp_d    = dp_out;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          scan_d  = ~(4'b0001 << dig_q);
          seg_d   = (blink_off || lz_blank) ? 7'h7F : hex2seg(nib);
          dp_d    = blink_off ? 1'b1 : ~bus.dp_mask[dig_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          dig_d   = dig_q + 1'b1;
          scan_d  = 4'hF;
          seg_d   = 7'h7F;
          dp_d    = 1'b1;
          // frame end: last DRIVE cycle of digit 3
          if (dig_q == 2'd3) begin
            owner_d = bus.src1_req;
            if (frame_q == FRAMES_LAST) begin
              frame_d = '0;
              phase_d = ~phase_q;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // state and output registers; reset blanks the display immediately
  always_ff @(posedge base_scan_clock or posedge RESETn) begin
    if (RESETn) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      owner_q  <= 1'b0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      scan_out <= 4'hF;
      seg_out  <= 7'h7F;
      dp_out   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      owner_q  <= owner_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      scan_out <= scan_d;
      seg_out  <= seg_d;
      dp_out   <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Scoreboard bench for seven_seg_display_ctrl (DWELL=4, BLANK=1, BLINK_FRAMES=2).
// Stimulus pushes the expected digit image just before each digit is sampled;
// a monitor pops one entry at every digit start and checks dwell length.
module tb_seven_seg_display_ctrl;
  localparam int DW = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       RESETn;
  logic [3:0] scan_out;
  logic [6:0] seg_out;
  logic       dp_out;

  seven_seg_display_ctrl_if bus ();

  seven_seg_display_ctrl #(.DWELL(DW), .BLANK(1), .BLINK_FRAMES(BF)) dut (
    .base_scan_clock(clk),
    .RESETn         (RESETn),
    .bus            (bus),
    .scan_out       (scan_out),
    .seg_out        (seg_out),
    .dp_out         (dp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] scan;
    logic [6:0] seg;
    logic       dp;
    logic       gnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  logic owner_m;
  int   fcnt_m;
  logic phase_m;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
    endcase
  endfunction

  function automatic exp_t expect_digit(input int k);
    exp_t e;
    logic [15:0] d;
    d = owner_m ? bus.src1_data : bus.src0_data;
    e.scan = ~(4'b0001 << k);
    e.seg  = seg_of(d[k*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (d >> (4*k)) == 16'h0) e.seg = 7'h7F;
`endif
    e.dp   = ~bus.dp_mask[k];
    if (phase_m && bus.blink_mask[k]) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    e.gnt  = owner_m;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    vectors++;
    if (scan_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 || bus.src1_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got scan=%b seg=%b dp=%b gnt=%b, want scan=1111 seg=1111111 dp=1 gnt=0",
               name, scan_out, seg_out, dp_out, bus.src1_gnt);
    end
  endtask

  // one digit slot (BLANK + DWELL cycles), starting at the negedge before it is sampled.
  // act: 1 raise req mid, 2 change src0 mid, 3 reset mid, 5 req pulse, 6 drop req mid
  task automatic dstep(input int k, input int act);
    exp_q.push_back(expect_digit(k));
    if (act == 0) tick(5);
    else begin
      tick(2);
      case (act)
        1: bus.src1_req = 1'b1;
        2: bus.src0_data = 16'h5678;
        5: bus.src1_req = 1'b1;
        6: bus.src1_req = 1'b0;
        default: ;
      endcase
      if (act == 3) begin
        #2 RESETn = 1'b1;
        #1 check_reset("reset_mid_digit");
        return;
      end
      if (act == 5) begin
        tick(1);
        bus.src1_req = 1'b0;
        tick(2);
      end else tick(3);
    end
    if (k == 3) begin
      owner_m = bus.src1_req;
      fcnt_m++;
      if (fcnt_m == BF) begin
        fcnt_m  = 0;
        phase_m = ~phase_m;
      end
    end
  endtask

  task automatic frame(input int act_dig, input int act);
    for (int k = 0; k < 4; k++) begin
      dstep(k, (k == act_dig) ? act : 0);
      if (k == act_dig && act == 3) return;
    end
  endtask

  // monitor: compare at each digit start, check dwell at each digit end
  logic [3:0] prev_scan = 4'hF;
  int         run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (RESETn !== 1'b0) begin
      prev_scan = 4'hF;
      run = 0;
    end else begin
      if (scan_out != 4'hF) begin
        if (prev_scan == 4'hF) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_digit: got scan=%b seg=%b, want no digit", scan_out, seg_out);
          end else begin
            e = exp_q.pop_front();
            if (scan_out !== e.scan || seg_out !== e.seg || dp_out !== e.dp || bus.src1_gnt !== e.gnt) begin
              miscompares++;
              $display("FAIL digit_image: got scan=%b seg=%b dp=%b gnt=%b, want scan=%b seg=%b dp=%b gnt=%b",
                       scan_out, seg_out, dp_out, bus.src1_gnt, e.scan, e.seg, e.dp, e.gnt);
            end
          end
          run = 1;
        end else if (scan_out != prev_scan) begin
          vectors++;
          miscompares++;
          $display("FAIL no_blank_gap: got scan %b -> %b, want 1111 between digits", prev_scan, scan_out);
          run = 1;
        end else run++;
      end else if (prev_scan != 4'hF) begin
        vectors++;
        if (run != DW) begin
          miscompares++;
          $display("FAIL dwell_length: got %0d cycles on scan=%b, want %0d", run, prev_scan, DW);
        end
      end
      prev_scan = scan_out;
    end
  end

  initial begin
    RESETn          = 1'b1;
    bus.src0_data   = 16'h1234;
    bus.src1_data   = 16'hABCD;
    bus.src1_req    = 1'b0;
    bus.blink_mask  = 4'b0000;
    bus.dp_mask     = 4'b0000;
    owner_m = 1'b0;
    fcnt_m  = 0;
    phase_m = 1'b0;
    tick(3);
    check_reset("reset_state");
    RESETn = 1'b0;

    frame(0, 0);                                   // 1234 plain
    bus.dp_mask = 4'b0101; frame(0, 0);            // decimal points on digits 0, 2
    bus.dp_mask = 4'b0000; frame(1, 5);            // short req pulse, ignored
    frame(1, 1);                                   // req raised mid-frame
    frame(2, 6);                                   // source 1 owns (DCBA), req dropped
    frame(0, 0);                                   // back to source 0
    bus.blink_mask = 4'b0001;
    for (int f = 0; f < 4; f++) frame(0, 0);       // two lit frames, two blank
    bus.blink_mask = 4'b0000;
    frame(1, 2);                                   // src0 changes mid digit 1
    bus.src1_req = 1'b1; frame(0, 0);              // grant at this frame end
    frame(2, 3);                                   // reset during digit 2 drive

    bus.src1_req = 1'b0;
    owner_m = 1'b0;
    fcnt_m  = 0;
    phase_m = 1'b0;
    tick(2);
    check_reset("reset_held");
    bus.src0_data = 16'h0050;
    RESETn = 1'b0;
    frame(0, 0);                                   // leading zeros 0050
    bus.src0_data = 16'h0000;
    bus.dp_mask   = 4'b0010;
    frame(0, 0);                                   // all zero, dp on digit 1

    RESETn = 1'b1;
    tick(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
- Scan controller and display arbiter for the 4-digit multiplexed seven-segment display.
- Sequences digit enables with a programmable dwell time and an inter-digit blanking gap to suppress ghosting.
- Shares the display between two sources: source 0 is the time-of-day display and the default owner; source 1 is the set/alarm display, which uses a req/gnt handshake.
- Handles hex-to-segment decode and per-digit blinking. Sits between the clock/alarm datapath and the board's digit and segment pins.

Parameters:
DWELL, 250, base_scan_clock cycles each digit is driven (>=1)
BLANK, 2, all-off cycles between consecutive digits (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (1..255)

Ports:
base_scan_clock  in  1  scan clock, all state on its rising edge
RESETn  in  1  asynchronous, active-high reset
src0_data  in  16  source 0 digits, nibble k -> digit k (digit 0 = U1, least significant)
src1_data  in  16  source 1 digits, same packing
src1_req  in  1  source 1 requests the display
src1_gnt  out  1  source 1 owns the display
blink_mask  in  4  bit k set -> digit k blinks (applies to current owner)
dp_mask  in  4  bit k set -> decimal point lit on digit k
scan_out  out  4  digit enables, active-low one-hot (1110=U1 ... 0111=U4), 1111=all off
seg_out  out  7  segments a..g at bits 0..6, active-low
dp_out  out  1  decimal point, active-low

Behaviour:
- Reset (async, RESETn=1):
  - scan_out=1111, seg_out=1111111, dp_out=1, src1_gnt=0.
  - Owner is source 0; FSM state BLANK; digit index=0; dwell counter=0; frame count=0; blink phase=0.
- FSM, two states:
  - BLANK: scan_out=1111; stays BLANK cycles.
  - DRIVE: exactly one enable low for DWELL cycles.
  - BLANK->DRIVE: registers digit index, owner's nibble, blink and dp bits.
  - DRIVE->BLANK: increments digit index mod 4 (3 wraps to 0).
- All outputs are registered. scan_out, seg_out and dp_out change on the same edge; segments are never visible on a disabled digit.
- Frame = 4*(DWELL+BLANK) cycles. Frame end = last DRIVE cycle of digit 3.
- After reset release: BLANK cycles all-off, then digit 0 driven.
- Decode: hex 0-F standard patterns, e.g. 0->1000000, 1->1111001, 8->0000000, F->0001110.
- Arbitration, evaluated only at frame end so a frame never mixes sources:
  - Owner 0 and src1_req=1 -> owner 1; src1_gnt rises on the frame-end edge.
  - Owner 1 and src1_req=0 -> owner 0; src1_gnt falls on the frame-end edge.
  - Otherwise owner unchanged. A req pulse shorter than a frame that misses frame end is ignored.
  - Source 1 must hold req while it needs the display. Grant latency is at most one frame.
- Blink:
  - Frame counter increments at frame end. On reaching BLINK_FRAMES it clears and blink phase toggles.
  - While phase=1, a digit with blink_mask set drives seg_out=1111111 and dp_out=1. Its enable still scans, so timing is unchanged.
- Data and masks are sampled only at BLANK->DRIVE; changes mid-dwell take effect on the next digit.
- Reset mid-frame forces all outputs to reset values immediately and restarts at digit 0 after release.
- Counter widths must hold DWELL-1 and BLANK-1 without overflow.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: for the current owner's data, digits 3, 2, 1 are blanked (seg_out=1111111) while they and all higher digits are 0. Digit 0 is never blanked. A blanked digit's dp bit still applies.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan (DWELL=4, BLANK=1, BLINK_FRAMES=2, frame=20 cycles):
- Reset release, src0_data=16'h1234 -> 1 cycle 1111, then 4 cycles each of 1110/seg 4 (0011001), 1101/3, 1011/2, 0111/1, separated by single 1111 cycles; repeats every 20 cycles.
- src1_req raised mid-frame, src1_data=16'hABCD -> src1_gnt rises at frame end; next frame shows D,C,B,A; no frame mixes sources; req dropped -> gnt falls at next frame end, source 0 data returns.
- blink_mask=0001 -> digit 0 segments lit for 2 frames, blank for 2 frames, while scan_out keeps cycling.
- RESETn asserted during digit 2 DRIVE -> same-cycle scan_out=1111, seg_out=1111111, src1_gnt=0; after release the scan restarts at digit 0.
- src0_data changed mid-dwell of digit 1 -> current digit unchanged; new value appears from digit 2.
- LEADING_ZERO_BLANK_EN defined, src0_data=16'h0050 -> digits 3, 2 blank; digit 1 shows 5, digit 0 shows 0. With 16'h0000, only digit 0 is lit.
